mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width on all ports.
REQ-002 Parameter DATA_W, default 16, data width; mask width is DATA_W/8.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 i_read  in  1; i_address  in  ADDR_W  -- instruction-port read request, held until i_resp.
REQ-007 i_resp  out  1; i_rdata  out  DATA_W  -- instruction-port completion strobe and read data.
REQ-008 d_read, d_write  in  1 each; d_wmask  in  DATA_W/8; d_address  in  ADDR_W; d_wdata  in  DATA_W  -- data-port request, held until d_resp.
REQ-009 d_resp  out  1; d_rdata  out  DATA_W  -- data-port completion strobe and read data.
REQ-010 mem_read, mem_write  out  1 each; mem_wmask  out  DATA_W/8; mem_address  out  ADDR_W; mem_wdata  out  DATA_W  -- downstream memory request.
REQ-011 mem_resp  in  1; mem_rdata  in  DATA_W  -- downstream completion and read data.

Function
REQ-012 FSM states SHALL be IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D.
REQ-013 In IDLE, a pending request SHALL latch opcode, address, wmask and wdata and move to SERVE_x on the next edge.
REQ-014 If neither port requests, the FSM SHALL stay in IDLE.
REQ-015 In SERVE_x, the mem_* outputs SHALL be driven from latched values only, and input changes SHALL be ignored.
REQ-016 In SERVE_x with mem_resp=1, the FSM SHALL capture mem_rdata and move to RESP_x.
REQ-017 In SERVE_x with mem_resp=0, the FSM SHALL hold and keep the mem_* outputs stable.
REQ-018 In RESP_x, x_resp SHALL be 1 for exactly one cycle with x_rdata equal to the captured data, followed by IDLE.
REQ-019 Minimum latency SHALL be 2 cycles: request seen in cycle N, memory access in N+1, x_resp in N+2.
REQ-020 i_resp and d_resp SHALL never both be asserted in the same cycle.
REQ-021 Only one of mem_read or mem_write SHALL be high in any cycle, and only in SERVE states.
REQ-022 If d_read=1 and d_write=1 together, the access SHALL be treated as a write.
REQ-023 A write with d_wmask=0 SHALL still be issued and SHALL complete with d_resp.
REQ-024 A write SHALL return d_rdata equal to the captured mem_rdata; no other semantics apply.
REQ-025 Addresses SHALL pass through unmodified; alignment is the memory's job.
REQ-026 A request re-seen in IDLE, at the cycle after RESP, SHALL be a new transaction; requesters drop the request after seeing resp.

Reset
REQ-027 rst SHALL force IDLE.
REQ-028 Under rst, all mem_* outputs, i_resp and d_resp SHALL be 0, and i_rdata/d_rdata SHALL be 0.
REQ-029 Reset mid-transaction SHALL abort it with no resp issued.
REQ-030 Reset SHALL set the round-robin pointer to "last granted = I".

Configuration
REQ-031 Macro MEM_ARB_RR_EN SHALL select the arbitration policy.
REQ-032 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the port not granted last.
REQ-033 With MEM_ARB_RR_EN defined, the pointer SHALL update on entry to SERVE_x.
REQ-034 Without MEM_ARB_RR_EN, the data port SHALL always win ties, and no pointer register exists.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the FSM state enum, the grant enum (GNT_I, GNT_D) and the default width constants.
REQ-036 The block SHALL be a single module with no sub-module; the latch/capture registers and the FSM live in mem_arbiter.

Verification
REQ-037 Reset, then i_read=1, i_address=0x0010, mem_rdata=0x1234 with immediate mem_resp -> mem_read=1 in cycle 1; i_resp=1 and i_rdata=0x1234 in cycle 2.
REQ-038 d_write=1, d_address=0x0021, d_wmask=2'b10, d_wdata=0xABCD -> one SERVE cycle with mem_write=1, mem_address=0x0021, mem_wmask=2'b10; d_resp in cycle 2; i_resp stays 0.
REQ-039 i_read and d_read both held continuously, built without MEM_ARB_RR_EN -> grants D,D,D... and I starves.
REQ-040 Same stimulus, built with MEM_ARB_RR_EN -> grants D,I,D,I, each completion spaced 3 cycles.
REQ-041 mem_resp delayed 4 cycles during d_read -> mem_* outputs held stable for 5 cycles; d_address changed mid-wait has no effect; one d_resp.
REQ-042 rst asserted in the SERVE_D cycle -> next cycle IDLE, all outputs 0, no d_resp ever issued for the aborted access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the two-port memory arbiter.
//   state_t        - arbiter FSM states
//   gnt_t          - which requester owns the current transaction
//   MEM_ARB_ADDR_W - default byte-address width
//   MEM_ARB_DATA_W - default data width (byte mask is DATA_W/8)
package mem_arb_pkg;

  localparam int unsigned MEM_ARB_ADDR_W = 16;
  localparam int unsigned MEM_ARB_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } state_t;

  typedef enum logic {
    GNT_I,
    GNT_D
  } gnt_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction port and a data port onto a single
// downstream memory port, one transaction at a time.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   i_read, i_address              instruction read request (held until i_resp)
//   i_resp, i_rdata                instruction completion strobe / read data
//   d_read, d_write, d_wmask,
//   d_address, d_wdata             data request (held until d_resp)
//   d_resp, d_rdata                data completion strobe / read data
//   mem_read, mem_write, mem_wmask,
//   mem_address, mem_wdata         downstream request (valid only in SERVE states)
//   mem_resp, mem_rdata            downstream completion / read data
//
// Configuration
//   MEM_ARB_RR_EN  defined   : simultaneous requests alternate (round robin)
//                  undefined : data port always wins ties
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ARB_ADDR_W,
  parameter int unsigned DATA_W = MEM_ARB_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_address,
  output logic                i_resp,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_read,
  input  logic                d_write,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [ADDR_W-1:0]   d_address,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_resp,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned MASK_W = DATA_W / 8;

  state_t              r_state;
  state_t              w_next;
  gnt_t                w_grant;
  logic                w_i_req;
  logic                w_d_req;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [MASK_W-1:0]   r_wmask;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
`ifdef MEM_ARB_RR_EN
  gnt_t                r_last;
`endif

  // Arbitration; d_read together with d_write is still a single data request.
  always_comb begin
    w_i_req = i_read;
    w_d_req = d_read | d_write;
    w_grant = GNT_D;
    if (w_i_req && w_d_req) begin
`ifdef MEM_ARB_RR_EN
      w_grant = (r_last == GNT_D) ? GNT_I : GNT_D;
`else
      w_grant = GNT_D;
`endif
    end else if (w_i_req) begin
      w_grant = GNT_I;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_i_req || w_d_req) w_next = (w_grant == GNT_I) ? SERVE_I : SERVE_D;
      SERVE_I: if (mem_resp) w_next = RESP_I;
      SERVE_D: if (mem_resp) w_next = RESP_D;
      RESP_I:  w_next = IDLE;
      RESP_D:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch and response capture. The pointer is written on the same
  // edge that enters SERVE_x, so it always names the port being served.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wmask <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef MEM_ARB_RR_EN
      r_last  <= GNT_I;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_i_req || w_d_req) begin
            if (w_grant == GNT_I) begin
              r_write <= 1'b0;
              r_addr  <= i_address;
              r_wmask <= '0;
              r_wdata <= '0;
            end else begin
              r_write <= d_write;
              r_addr  <= d_address;
              r_wmask <= d_wmask;
              r_wdata <= d_wdata;
            end
`ifdef MEM_ARB_RR_EN
            r_last <= w_grant;
`endif
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) r_rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // FSM: outputs. Gated by rst so everything is quiet for the whole reset cycle.
  always_comb begin
    i_resp      = 1'b0;
    i_rdata     = '0;
    d_resp      = 1'b0;
    d_rdata     = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wmask   = '0;
    mem_address = '0;
    mem_wdata   = '0;
    if (!rst) begin
      case (r_state)
        SERVE_I: begin
          mem_read    = 1'b1;
          mem_address = r_addr;
        end
        SERVE_D: begin
          mem_read    = ~r_write;
          mem_write   = r_write;
          mem_wmask   = r_wmask;
          mem_address = r_addr;
          mem_wdata   = r_wdata;
        end
        RESP_I: begin
          i_resp  = 1'b1;
          i_rdata = r_rdata;
        end
        RESP_D: begin
          d_resp  = 1'b1;
          d_rdata = r_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule
